// File: rtl/obf_key_ctrl_if.sv
// Serial key-configuration channel for obf_key_ctrl.
//   cfg_valid : source has a key/parity bit on cfg_bit
//   cfg_ready : controller accepts the beat this cycle
//   cfg_bit   : serial data, key bits LSB first, then one even-parity bit
//   cfg_last  : marks the parity bit (final beat of a frame)
// Handshake: a beat transfers on a rising clk edge where cfg_valid && cfg_ready
// are both high. The source holds cfg_bit/cfg_last stable while cfg_valid is
// high and not yet accepted; cfg_ready never depends on cfg_valid.
interface obf_key_ctrl_if;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_bit;
  logic cfg_last;

  modport master (output cfg_valid, output cfg_bit, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_bit, input cfg_last, output cfg_ready);
endinterface

// File: rtl/obf_key_ctrl.sv
// Key controller for key-gated obfuscated combinational netlists.
// Collects serial key frames, checks length and even parity, commits good
// frames to key_out and raises key_valid only after a settle window so the
// netlist outputs are never sampled mid-transition.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   cfg        : serial key channel (slave side)
//   zeroize    : single-cycle request to clear the active key
//   key_out    : active key, bit i drives netlist key input s_i
//   key_valid  : key_out stable and settled
//   locked     : key committed and frozen (LOCK_ONCE=1 only)
//   cfg_err    : one-cycle pulse on a rejected frame
//   state_dbg  : current FSM state for observation
module obf_key_ctrl #(
  parameter int KEY_W     = 2,
  parameter int SETTLE    = 4,
  parameter int LOCK_ONCE = 1
) (
  input  logic               clk,
  input  logic               rst,
  obf_key_ctrl_if.slave      cfg,
  input  logic               zeroize,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               locked,
  output logic               cfg_err,
  output logic [2:0]         state_dbg
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   shadow_q;
  logic [CNT_W-1:0]   count_q;
  logic               parity_q;
  logic [8:0]         settle_q;
  logic               key_valid_q;
  logic               locked_q;
  logic               cfg_err_q;
  logic [KEY_W-1:0]   key_q;

  logic               ready;
  logic               beat;
  logic               zero_req;
  logic               check_pass;
  logic               settle_done;
  logic               shift_en;
  logic               parity_en;
  logic               commit;
  logic               err_set;
  logic [CNT_W-1:0]   shift_idx;

  assign beat        = cfg.cfg_valid && ready;
  assign zero_req    = zeroize && !locked_q;
  assign check_pass  = (count_q == CNT_W'(KEY_W)) && ((^shadow_q ^ parity_q) == 1'b0);
  // The counter is about to hit zero this cycle.
  assign settle_done = (settle_q == 9'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; zeroize overrides everything while unlocked.
  always_comb begin
    state_d = state_q;
    if (zero_req) begin
      state_d = ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (beat && !cfg.cfg_last) state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (beat) begin
            if (cfg.cfg_last)                    state_d = ST_CHECK;
            else if (count_q == CNT_W'(KEY_W))   state_d = ST_DRAIN;
          end
        end
        ST_DRAIN:  if (beat && cfg.cfg_last) state_d = ST_IDLE;
        ST_CHECK:  state_d = check_pass ? ST_SETTLE : ST_IDLE;
        ST_SETTLE: if (settle_done) state_d = locked_q ? ST_LOCKED : ST_IDLE;
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath-control logic
  always_comb begin
    ready     = 1'b0;
    shift_en  = 1'b0;
    parity_en = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    shift_idx = count_q;
    if (!rst && !locked_q &&
        (state_q == ST_IDLE || state_q == ST_SHIFT || state_q == ST_DRAIN))
      ready = 1'b1;
    if (!zero_req) begin
      case (state_q)
        ST_IDLE: begin
          shift_idx = '0;
          if (beat) begin
            if (cfg.cfg_last) err_set  = 1'b1;  // zero-length frame
            else              shift_en = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (beat) begin
            if (cfg.cfg_last)                   parity_en = 1'b1;
            else if (count_q < CNT_W'(KEY_W))   shift_en  = 1'b1;
            else                                err_set   = 1'b1;  // overlong
          end
        end
        ST_CHECK: begin
          if (check_pass) commit  = 1'b1;
          else            err_set = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      count_q     <= '0;
      parity_q    <= 1'b0;
      settle_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= err_set;
      if (zero_req) begin
        key_q       <= '0;
        shadow_q    <= '0;
        count_q     <= '0;
        key_valid_q <= 1'b0;
        // One extra cycle so key_valid rises SETTLE+1 cycles after the request,
        // matching the frame path where CHECK takes the first cycle.
        settle_q    <= 9'(SETTLE + 1);
      end else begin
        if (shift_en) begin
          for (int i = 0; i < KEY_W; i++)
            if (shift_idx == CNT_W'(i)) shadow_q[i] <= cfg.cfg_bit;
          count_q <= shift_idx + CNT_W'(1);
        end
        if (parity_en) parity_q <= cfg.cfg_bit;
        if (err_set || commit) count_q <= '0;
        if (commit) begin
          key_q       <= shadow_q;
          key_valid_q <= 1'b0;
          settle_q    <= 9'(SETTLE);
          if (LOCK_ONCE != 0) locked_q <= 1'b1;
        end
        if (state_q == ST_SETTLE) begin
          if (settle_done) key_valid_q <= 1'b1;
          settle_q <= settle_q - 9'd1;
        end
      end
    end
  end

  assign cfg.cfg_ready = ready;
  assign key_out       = key_q;
  assign key_valid     = key_valid_q;
  assign locked        = locked_q;
  assign cfg_err       = cfg_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_obf_key_ctrl.sv
// Bench for obf_key_ctrl: one locking instance (LOCK_ONCE=1) and one
// free-running instance (LOCK_ONCE=0) share clock and reset.
module tb_obf_key_ctrl;
  localparam int KEY_W  = 2;
  localparam int SETTLE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obf_key_ctrl_if if_l ();
  obf_key_ctrl_if if_f ();

  logic             zeroize_l = 1'b0, zeroize_f = 1'b0;
  logic [KEY_W-1:0] key_out_l, key_out_f;
  logic             key_valid_l, key_valid_f;
  logic             locked_l, locked_f;
  logic             cfg_err_l, cfg_err_f;
  logic [2:0]       state_l, state_f;

  obf_key_ctrl #(.KEY_W(KEY_W), .SETTLE(SETTLE), .LOCK_ONCE(1)) u_lock (
    .clk(clk), .rst(rst), .cfg(if_l.slave), .zeroize(zeroize_l),
    .key_out(key_out_l), .key_valid(key_valid_l), .locked(locked_l),
    .cfg_err(cfg_err_l), .state_dbg(state_l)
  );

  obf_key_ctrl #(.KEY_W(KEY_W), .SETTLE(SETTLE), .LOCK_ONCE(0)) u_free (
    .clk(clk), .rst(rst), .cfg(if_f.slave), .zeroize(zeroize_f),
    .key_out(key_out_f), .key_valid(key_valid_f), .locked(locked_f),
    .cfg_err(cfg_err_f), .state_dbg(state_f)
  );

  int checks = 0;
  int errors = 0;

  // reference model state for the free instance
  logic [KEY_W-1:0] model_key = '0;
  bit               model_valid = 1'b0;
  bit               mon_en = 1'b0;
  int               err_seen_f = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (cfg_err_f === 1'b1) err_seen_f++;
    if (mon_en && key_valid_f === 1'b1) chk("valid_key_match", 32'(key_out_f), 32'(model_key));
  end

  // driver tasks (all start and end at posedge+1)
  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input bit sel, input logic v, input logic b, input logic last);
    if (sel) begin if_l.cfg_valid = v; if_l.cfg_bit = b; if_l.cfg_last = last; end
    else     begin if_f.cfg_valid = v; if_f.cfg_bit = b; if_f.cfg_last = last; end
  endtask

  task automatic send_beat(input bit sel, input logic b, input logic last);
    bit done = 1'b0;
    int n = 0;
    drive(sel, 1'b1, b, last);
    while (!done && n < 100) begin
      @(negedge clk);
      if ((sel ? if_l.cfg_ready : if_f.cfg_ready) === 1'b1) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    if (!done) chk("beat_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input int n, input logic par);
    for (int i = 0; i < n; i++) send_beat(sel, data[i], 1'b0);
    send_beat(sel, par, 1'b1);
  endtask

  // called right after the cfg_last handshake of a frame that must commit
  task automatic settle_check(input bit sel, input logic [KEY_W-1:0] exp_key);
    wait_cycles(1);
    chk("commit_key", 32'(sel ? key_out_l : key_out_f), 32'(exp_key));
    chk("commit_valid_drop", 32'(sel ? key_valid_l : key_valid_f), 32'd0);
    wait_cycles(SETTLE - 1);
    chk("valid_early", 32'(sel ? key_valid_l : key_valid_f), 32'd0);
    wait_cycles(1);
    chk("valid_on_time", 32'(sel ? key_valid_l : key_valid_f), 32'd1);
  endtask

  task automatic reset_pulse_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_key_f"},   32'(key_out_f),    32'd0);
    chk({tag, "_valid_f"}, 32'(key_valid_f),  32'd0);
    chk({tag, "_ready_f"}, 32'(if_f.cfg_ready), 32'd0);
    chk({tag, "_key_l"},   32'(key_out_l),    32'd0);
    chk({tag, "_lock_l"},  32'(locked_l),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e0, ndata, exp_err;
    logic [7:0] data;
    logic par;
    bit commit;

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // reset values
    #3;
    chk("rst_key", 32'(key_out_l), 32'd0);
    chk("rst_valid", 32'(key_valid_l), 32'd0);
    chk("rst_locked", 32'(locked_l), 32'd0);
    chk("rst_err", 32'(cfg_err_l), 32'd0);
    chk("rst_ready", 32'(if_l.cfg_ready), 32'd0);
    chk("rst_ready_f", 32'(if_f.cfg_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(1);
    chk("idle_ready", 32'(if_l.cfg_ready), 32'd1);

    // locking instance: bits 1,0 parity 1 -> key 2'b01
    send_frame(1'b1, 8'b01, 2, 1'b1);
    settle_check(1'b1, 2'b01);
    chk("lock_set", 32'(locked_l), 32'd1);
    chk("lock_ready", 32'(if_l.cfg_ready), 32'd0);
    zeroize_l = 1'b1;
    wait_cycles(1);
    zeroize_l = 1'b0;
    wait_cycles(SETTLE + 2);
    chk("lock_zeroize_key", 32'(key_out_l), 32'd1);
    chk("lock_zeroize_valid", 32'(key_valid_l), 32'd1);

    // free instance: bad parity then good parity
    e0 = err_seen_f;
    send_frame(1'b0, 8'b11, 2, 1'b1);
    wait_cycles(3);
    chk("parity_err_count", 32'(err_seen_f - e0), 32'd1);
    chk("parity_err_key", 32'(key_out_f), 32'd0);
    chk("parity_err_valid", 32'(key_valid_f), 32'd0);
    send_frame(1'b0, 8'b11, 2, 1'b0);
    settle_check(1'b0, 2'b11);

    // zeroize together with a beat
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    zeroize_f = 1'b1;
    wait_cycles(1);
    zeroize_f = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("zeroize_key", 32'(key_out_f), 32'd0);
    chk("zeroize_valid", 32'(key_valid_f), 32'd0);
    wait_cycles(SETTLE);
    chk("zeroize_valid_early", 32'(key_valid_f), 32'd0);
    wait_cycles(1);
    chk("zeroize_valid_on_time", 32'(key_valid_f), 32'd1);

    // overlong frame: error on 3rd data beat, remaining beats drained
    e0 = err_seen_f;
    send_beat(1'b0, 1'b1, 1'b0);
    send_beat(1'b0, 1'b1, 1'b0);
    send_beat(1'b0, 1'b1, 1'b0);
    chk("overlong_err_pulse", 32'(cfg_err_f), 32'd1);
    send_beat(1'b0, 1'b0, 1'b0);
    send_beat(1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    chk("overlong_err_count", 32'(err_seen_f - e0), 32'd1);
    chk("overlong_key", 32'(key_out_f), 32'd0);
    chk("drain_ready", 32'(if_f.cfg_ready), 32'd1);
    send_frame(1'b0, 8'b10, 2, 1'b1);
    settle_check(1'b0, 2'b10);

    // reset in the middle of a frame
    send_beat(1'b0, 1'b1, 1'b0);
    reset_pulse_check("rst_shift");
    wait_cycles(1);
    send_frame(1'b0, 8'b11, 2, 1'b0);
    settle_check(1'b0, 2'b11);

    // reset during the settle window
    send_frame(1'b0, 8'b01, 2, 1'b1);
    wait_cycles(2);
    reset_pulse_check("rst_settle");
    wait_cycles(1);
    send_frame(1'b0, 8'b10, 2, 1'b1);
    settle_check(1'b0, 2'b10);

    // randomized frames against the reference model
    model_key   = 2'b10;
    model_valid = 1'b1;
    mon_en      = 1'b1;
    for (int f = 0; f < 200; f++) begin
      ndata = int'($urandom_range(0, KEY_W + 2));
      data  = 8'($urandom);
      par   = 1'(($countones(data[KEY_W-1:0])) % 2);
      if ($urandom_range(0, 3) == 0) par = 1'($urandom_range(0, 1));
      commit  = (ndata == KEY_W) && ((($countones(data[KEY_W-1:0]) + int'(par)) % 2) == 0);
      exp_err = commit ? 0 : 1;
      e0 = err_seen_f;
      for (int i = 0; i < ndata; i++) begin
        if ($urandom_range(0, 1) == 1) wait_cycles(1);
        send_beat(1'b0, data[i], 1'b0);
      end
      if ($urandom_range(0, 1) == 1) wait_cycles(1);
      send_beat(1'b0, par, 1'b1);
      if (commit) begin
        wait_cycles(1);
        model_key   = data[KEY_W-1:0];
        model_valid = 1'b1;
        wait_cycles(SETTLE + 1);
      end else begin
        wait_cycles(SETTLE + 2);
      end
      chk("rand_key", 32'(key_out_f), 32'(model_key));
      chk("rand_valid", 32'(key_valid_f), 32'(model_valid));
      chk("rand_err", 32'(err_seen_f - e0), 32'(exp_err));
    end
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
